// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared state type and ratio helper for clock_gen
package clock_gen_pkg;

    typedef enum logic [1:0] {
        RUN,
        STOPPED,
        STEP
    } cg_state_e;

    // Last half-period count for a select value: 2^sel - 1.
    function automatic logic [31:0] term_count(input logic [31:0] sel);
        return (32'd1 << sel) - 32'd1;
    endfunction

endpackage

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - programmable power-of-two clock divider with stop, park and single-step
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  clk_sel,
    input  logic              stop_clk,
    input  logic              step,
    output logic              clk_out,
    output logic              rise_stb,
    output logic              fall_stb,
    output logic              running,
    output logic [PCNT_W-1:0] period_cnt
);

    localparam int HC_W = (1 << SEL_W) - 1;

    logic [HC_W-1:0]  hc;
    logic [SEL_W-1:0] sel_q;
    cg_state_e        state;
    logic             at_tc;

    assign at_tc = ({{(32-HC_W){1'b0}}, hc} == term_count({{(32-SEL_W){1'b0}}, sel_q}));

    // sel_q only moves on a 1->0 toggle so a ratio change never truncates a high phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_out    <= 1'b1;
            hc         <= '0;
            period_cnt <= '0;
            rise_stb   <= 1'b0;
            fall_stb   <= 1'b0;
            running    <= 1'b1;
            state      <= RUN;
            sel_q      <= clk_sel;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            unique case (state)
                RUN: begin
                    if (at_tc) begin
                        hc      <= '0;
                        clk_out <= ~clk_out;
                        if (clk_out) begin
                            fall_stb   <= 1'b1;
                            period_cnt <= period_cnt + 1'b1;
                            sel_q      <= clk_sel;
                            if (stop_clk) begin
                                state   <= STOPPED;
                                running <= 1'b0;
                            end
                        end else begin
                            rise_stb <= 1'b1;
                        end
                    end else begin
                        hc <= hc + 1'b1;
                    end
                end
                STOPPED: begin
                    if (!stop_clk || step) begin
                        state    <= stop_clk ? STEP : RUN;
                        clk_out  <= 1'b1;
                        rise_stb <= 1'b1;
                        hc       <= '0;
                        running  <= 1'b1;
                    end
                end
                STEP: begin
                    if (at_tc) begin
                        hc <= '0;
                        if (clk_out) begin
                            clk_out    <= 1'b0;
                            fall_stb   <= 1'b1;
                            period_cnt <= period_cnt + 1'b1;
                            sel_q      <= clk_sel;
                        end else begin
                            // End of the stepped period: stay parked low, no edge.
                            state   <= STOPPED;
                            running <= 1'b0;
                        end
                    end else begin
                        hc <= hc + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - self-checking bench for clock_gen against a phase-level model
module tb_clock_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] clk_sel;
    logic       stop_clk;
    logic       step;
    logic       clk_out;
    logic       rise_stb;
    logic       fall_stb;
    logic       running;
    logic [3:0] period_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    clock_gen #(.SEL_W(3), .PCNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_sel    (clk_sel),
        .stop_clk   (stop_clk),
        .step       (step),
        .clk_out    (clk_out),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .running    (running),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    // Model: current level, cycles left in this phase, mode 0=run 1=stopped 2=step.
    int m_level, m_remain, m_sel, m_cnt, m_mode, m_rise, m_fall;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_level  = 1; m_sel = int'(clk_sel); m_remain = 1 << m_sel;
            m_cnt    = 0; m_mode = 0; m_rise = 0; m_fall = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_rise = 0; m_fall = 0;
            if (m_mode == 1) begin
                if (!stop_clk || step) begin
                    m_mode = stop_clk ? 2 : 0;
                    m_level = 1; m_rise = 1; m_remain = 1 << m_sel;
                end
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    if (m_level == 1) begin
                        m_level = 0; m_fall = 1; m_cnt = (m_cnt + 1) % 16;
                        m_sel = int'(clk_sel); m_remain = 1 << m_sel;
                        if (m_mode == 0 && stop_clk) m_mode = 1;
                    end else if (m_mode == 2) begin
                        m_mode = 1;
                    end else begin
                        m_level = 1; m_rise = 1; m_remain = 1 << m_sel;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("clk_out",    int'(clk_out),    m_level);
            check("rise_stb",   int'(rise_stb),   m_rise);
            check("fall_stb",   int'(fall_stb),   m_fall);
            check("running",    int'(running),    (m_mode != 1) ? 1 : 0);
            check("period_cnt", int'(period_cnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_fall(input string name);
        int n = 0;
        while (!fall_stb && n < 600) begin
            tick();
            n++;
        end
        check(name, int'(fall_stb), 1);
    endtask

    int n, rises, falls, cnt0;

    initial begin
        rst_n = 1'b0; clk_sel = 3'd0; stop_clk = 1'b0; step = 1'b0;
        repeat (3) tick();
        check("reset_clk_out", int'(clk_out), 1);
        check("reset_cnt", int'(period_cnt), 0);
        check("reset_running", int'(running), 1);

        // sel=0: toggles every cycle, first fall one cycle after release
        rst_n = 1'b1;
        tick();
        check("sel0_first_fall", int'(fall_stb), 1);
        check("sel0_c1", int'(clk_out), 0);
        tick(); check("sel0_c2", int'(clk_out), 1);
        tick(); check("sel0_c3", int'(clk_out), 0);
        repeat (5) tick();
        check("sel0_cnt8", int'(period_cnt), 4);

        // sel=2 then switch to 0 mid-high-phase: high still lasts 4 cycles
        rst_n = 1'b0; clk_sel = 3'd2;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clk_sel = 3'd0;
        n = 1;
        while (!fall_stb && n < 20) begin tick(); n++; end
        check("sel_switch_high_len", n, 4);
        tick(); check("sel_switch_rise", int'(rise_stb), 1);
        tick(); check("sel_switch_fall", int'(fall_stb), 1);

        // sel=1 then stop right after a fall: one more period, then park
        clk_sel = 3'd1;
        wait_fall("wait_fall_a");
        tick();
        wait_fall("wait_fall_b");
        cnt0 = int'(period_cnt);
        stop_clk = 1'b1;
        n = 0;
        while (running && n < 20) begin tick(); n++; end
        check("stop_latency", n, 4);
        check("stop_parked_low", int'(clk_out), 0);
        check("stop_cnt_inc", int'(period_cnt), (cnt0 + 1) % 16);

        // single step while stopped
        cnt0 = int'(period_cnt);
        rises = 0; falls = 0;
        step = 1'b1;
        tick();
        rises += int'(rise_stb); falls += int'(fall_stb);
        step = 1'b0;
        repeat (7) begin
            tick();
            rises += int'(rise_stb); falls += int'(fall_stb);
        end
        check("step_rises", rises, 1);
        check("step_falls", falls, 1);
        check("step_back_stopped", int'(running), 0);
        check("step_cnt_inc", int'(period_cnt), (cnt0 + 1) % 16);

        // resume and step together: RUN wins
        stop_clk = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        check("resume_running", int'(running), 1);
        check("resume_clk_out", int'(clk_out), 1);
        falls = 0;
        repeat (16) begin tick(); falls += int'(fall_stb); end
        check("resume_falls16", falls, 4);

        // park again, step, then reset in the middle of the step
        stop_clk = 1'b1;
        n = 0;
        while (running && n < 40) begin tick(); n++; end
        check("park2", int'(running), 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_in_step_clk_out", int'(clk_out), 1);
        check("rst_in_step_running", int'(running), 1);
        check("rst_in_step_cnt", int'(period_cnt), 0);

        // period_cnt wrap at 4 bits
        stop_clk = 1'b0; clk_sel = 3'd0;
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("wrap_15", int'(period_cnt), 15);
        tick();
        check("wrap_0", int'(period_cnt), 0);

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) < 5) clk_sel = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 3) stop_clk = ~stop_clk;
            step = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
            tick();
        end
        rst_n = 1'b1; step = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
